// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if
// Groups the request/response signals of the sequential multiplier.
//   start   : operation request, sampled on the rising clock edge
//   a, b    : W-bit unsigned multiplicand / multiplier
//   busy    : high while an operation is iterating
//   done    : one-cycle completion strobe
//   product : 2W-bit registered result of the last completed operation
// The master modport is the requester; the slave modport is the multiplier.
interface seq_multiplier_if #(parameter int W = 4);
  logic             start;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier
// Unsigned shift-add multiplier, one partial product per clock.
//   clk   : single clock, all state updates on the rising edge
//   reset : synchronous, active-high; returns to IDLE and clears all registers
//   bus   : seq_multiplier_if slave (start, a, b in; busy, done, product out)
// Sequence: IDLE accepts start, RUN iterates W times, DONE pulses done for
// one cycle and falls back to IDLE. The result is ready W edges after the
// accepting edge, so a continuously held start yields one operation every
// W+2 cycles.
module seq_multiplier #(
  parameter int W = 4
) (
  input  logic clk,
  input  logic reset,
  seq_multiplier_if.slave bus
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [W-1:0]     m;
  logic [W-1:0]     acc;
  logic [W-1:0]     q;
  logic [CW-1:0]    count;
  logic [2*W-1:0]   product;

  logic [W:0]       sum;
  logic             carry;
  logic [W-1:0]     acc_next;
  logic [W-1:0]     q_next;

  // One iteration: conditionally add M into ACC as a (W+1)-bit sum, then
  // shift {carry, ACC, Q} right by one with 0 entering the carry slot.
  // The carry is consumed by the same shift, so after every edge the stored
  // carry would be 0; it is therefore kept combinational only.
  always_comb begin
    sum      = {1'b0, acc} + (q[0] ? {1'b0, m} : {(W+1){1'b0}});
    carry    = sum[W];
    acc_next = {carry, sum[W-1:1]};
    q_next   = {sum[0], q[W-1:1]};
  end

  // Control FSM and datapath registers. Reset wins over everything; start is
  // only looked at in IDLE, so RUN/DONE ignore further requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            m     <= bus.a;
            q     <= bus.b;
            acc   <= '0;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          q     <= q_next;
          count <= count + 1'b1;
          // The W-th iteration publishes the post-shift {ACC, Q} directly.
          if (count == LAST) begin
            product <= {acc_next, q_next};
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.product = product;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier
// Directed bench for seq_multiplier at W=4 and W=8. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_seq_multiplier;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  seq_multiplier_if #(.W(4)) bus4 ();
  seq_multiplier_if #(.W(8)) bus8 ();

  seq_multiplier #(.W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  seq_multiplier #(.W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and log failures.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic getDone(input bit use8);
    return use8 ? bus8.done : bus4.done;
  endfunction

  function automatic logic getBusy(input bit use8);
    return use8 ? bus8.busy : bus4.busy;
  endfunction

  function automatic logic [31:0] getProd(input bit use8);
    return use8 ? 32'(bus8.product) : 32'(bus4.product);
  endfunction

  task automatic driveOp(input bit use8, input logic s, input logic [7:0] x,
                         input logic [7:0] y);
    if (use8) begin
      bus8.start = s;
      bus8.a     = x;
      bus8.b     = y;
    end else begin
      bus4.start = s;
      bus4.a     = x[3:0];
      bus4.b     = y[3:0];
    end
  endtask

  // Run one full operation starting at the current falling edge, checking
  // latency, busy length, stable product during RUN, result and single pulse.
  task automatic applyStimulus(input bit use8, input logic [7:0] x,
                               input logic [7:0] y, input logic [31:0] expected,
                               input int lat, input string tag);
    logic [31:0] prevProd;
    int edges;
    int busyCycles;
    int prodChanges;
    driveOp(use8, 1'b1, x, y);
    @(negedge clk);
    driveOp(use8, 1'b0, x, y);
    prevProd    = getProd(use8);
    edges       = 0;
    busyCycles  = 0;
    prodChanges = 0;
    while (!getDone(use8) && edges < 40) begin
      if (getBusy(use8)) busyCycles++;
      @(negedge clk);
      edges++;
      if (!getDone(use8) && getProd(use8) !== prevProd) prodChanges++;
    end
    checkOutput({tag, " latency"}, edges, lat);
    checkOutput({tag, " busy cycles"}, busyCycles, lat);
    checkOutput({tag, " product"}, getProd(use8), expected);
    checkOutput({tag, " product stable in RUN"}, prodChanges, 0);
    @(negedge clk);
    checkOutput({tag, " done single pulse"}, 32'(getDone(use8)), 0);
    checkOutput({tag, " busy after done"}, 32'(getBusy(use8)), 0);
  endtask

  initial begin
    int edges;
    int doneCount;
    int firstDone;
    int secondDone;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    driveOp(1'b0, 1'b0, 8'd0, 8'd0);
    driveOp(1'b1, 1'b0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);

    // Reset state of both widths.
    checkOutput("reset busy4", 32'(bus4.busy), 0);
    checkOutput("reset done4", 32'(bus4.done), 0);
    checkOutput("reset product4", 32'(bus4.product), 0);
    checkOutput("reset busy8", 32'(bus8.busy), 0);
    checkOutput("reset product8", 32'(bus8.product), 0);

    // Start in the very first cycle after reset deasserts.
    reset = 1'b0;
    applyStimulus(1'b0, 8'd13, 8'd11, 32'd143, 4, "13*11");
    applyStimulus(1'b0, 8'd15, 8'd15, 32'd225, 4, "15*15");
    applyStimulus(1'b0, 8'd0,  8'd9,  32'd0,   4, "0*9");
    applyStimulus(1'b0, 8'd1,  8'd15, 32'd15,  4, "1*15");
    applyStimulus(1'b0, 8'd8,  8'd2,  32'd16,  4, "8*2");

    // Idle with start low holds the last product.
    repeat (5) @(negedge clk);
    checkOutput("idle hold product", 32'(bus4.product), 16);
    checkOutput("idle busy", 32'(bus4.busy), 0);

    // Start and operand change on the 2nd RUN cycle are ignored.
    driveOp(1'b0, 1'b1, 8'd3, 8'd5);
    @(negedge clk);
    driveOp(1'b0, 1'b0, 8'd3, 8'd5);
    @(negedge clk);
    driveOp(1'b0, 1'b1, 8'd7, 8'd7);
    @(negedge clk);
    driveOp(1'b0, 1'b0, 8'd7, 8'd7);
    edges = 2;
    while (!bus4.done && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("busy-start latency", edges, 4);
    checkOutput("busy-start product", 32'(bus4.product), 15);
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus4.done) doneCount++;
    end
    checkOutput("busy-start extra done", doneCount, 0);
    checkOutput("busy-start product kept", 32'(bus4.product), 15);

    // Reset on the 3rd RUN cycle aborts the operation.
    driveOp(1'b0, 1'b1, 8'd9, 8'd9);
    @(negedge clk);
    driveOp(1'b0, 1'b0, 8'd9, 8'd9);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort busy", 32'(bus4.busy), 0);
    checkOutput("abort done", 32'(bus4.done), 0);
    checkOutput("abort product", 32'(bus4.product), 0);
    doneCount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus4.done) doneCount++;
    end
    checkOutput("abort no done", doneCount, 0);
    applyStimulus(1'b0, 8'd2, 8'd3, 32'd6, 4, "2*3 after abort");

    // Start held high: one acceptance per IDLE visit, every W+2 cycles.
    driveOp(1'b0, 1'b1, 8'd5, 8'd6);
    doneCount  = 0;
    firstDone  = -1;
    secondDone = -1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (bus4.done) begin
        if (doneCount == 0) firstDone = i;
        if (doneCount == 1) secondDone = i;
        doneCount++;
      end
    end
    driveOp(1'b0, 1'b0, 8'd5, 8'd6);
    checkOutput("held start done count", doneCount, 3);
    checkOutput("held start first done", firstDone, 4);
    checkOutput("held start period", secondDone - firstDone, 6);
    checkOutput("held start product", 32'(bus4.product), 30);
    @(negedge clk);
    checkOutput("held start released busy", 32'(bus4.busy), 0);

    // Eight-bit instance.
    applyStimulus(1'b1, 8'd255, 8'd255, 32'd65025, 8, "255*255");
    applyStimulus(1'b1, 8'd128, 8'd3,   32'd384,   8, "128*3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
